nios2_switches_edge: RTL and testbench

Parametrised Avalon-MM input PIO for the board switches. It adds input synchronisation, optional debouncing, per-bit edge capture with write-1-to-clear, and a maskable interrupt to the Nios II. It sits on the Nios II data master as a slave in the Qsys system, and its `irq` output feeds the processor interrupt controller.

---
 rtl/nios2_switches_edge_if.sv | 19 +
 rtl/nios2_switches_edge.sv | 129 ++++++++++++
 tb/tb_nios2_switches_edge.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/nios2_switches_edge_if.sv
// Avalon-MM slave bus for the switch PIO: word address, select, active-low write,
// 32-bit write data and registered read data.
interface nios2_switches_edge_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/nios2_switches_edge.sv
// Switch input PIO: synchroniser, optional per-bit debounce (SWITCHES_DEBOUNCE_EN),
// edge capture with write-1-to-clear, and a maskable level interrupt.
module nios2_switches_edge #(
    parameter int WIDTH           = 18,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    nios2_switches_edge_if.slave  bus,
    input  logic [WIDTH-1:0]      in_port,
    output logic                  irq
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_d;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] clr_mask;
    logic [31:0]      rd_mux;
    logic             wr;
    logic             unused_wdata;

    assign unused_wdata = ^bus.writedata;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= in_port;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

`ifdef SWITCHES_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic [CNT_W-1:0] cnt [WIDTH];

    // Each bit must disagree with stable for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable <= '0;
            for (int unsigned b = 0; b < WIDTH; b++) begin
                cnt[b] <= '0;
            end
        end else begin
            for (int unsigned b = 0; b < WIDTH; b++) begin
                if (sync[b] == stable[b]) begin
                    cnt[b] <= '0;
                end else if (cnt[b] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    stable[b] <= sync[b];
                    cnt[b]    <= '0;
                end else begin
                    cnt[b] <= cnt[b] + 1'b1;
                end
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            stable <= '0;
        end else begin
            stable <= sync;
        end
    end
`endif

    always_comb begin
        edge_det = '0;
        if (EDGE_TYPE == 0) begin
            edge_det = stable & ~stable_d;
        end else if (EDGE_TYPE == 1) begin
            edge_det = ~stable & stable_d;
        end else begin
            edge_det = stable ^ stable_d;
        end
    end

    assign wr       = bus.chipselect & ~bus.write_n;
    assign clr_mask = (wr && bus.address == 2'd3) ? bus.writedata[WIDTH-1:0] : '0;

    // Edge set is OR-ed after the clear so a same-cycle edge survives a W1C.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable_d    <= '0;
            irqmask     <= '0;
            edgecapture <= '0;
        end else begin
            stable_d    <= stable;
            edgecapture <= (edgecapture & ~clr_mask) | edge_det;
            if (wr && bus.address == 2'd2) begin
                irqmask <= bus.writedata[WIDTH-1:0];
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (bus.address)
            2'd0:    rd_mux[WIDTH-1:0] = stable;
            2'd2:    rd_mux[WIDTH-1:0] = irqmask;
            2'd3:    rd_mux[WIDTH-1:0] = edgecapture;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.readdata <= '0;
        end else begin
            bus.readdata <= rd_mux;
        end
    end

    assign irq = |(edgecapture & irqmask);

endmodule

// File: tb/tb_nios2_switches_edge.sv
// Directed bench for nios2_switches_edge: the driver queues expected read/irq values,
// a negedge monitor pops and compares them when the DUT presents the response.
module tb_nios2_switches_edge;

`ifdef SWITCHES_DEBOUNCE_EN
    localparam int LAT   = 6;
    localparam bit DB_EN = 1'b1;
`else
    localparam int LAT   = 3;
    localparam bit DB_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [17:0] in_port;
    logic        irq;

    nios2_switches_edge_if bus ();

    nios2_switches_edge #(
        .WIDTH           (18),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .EDGE_TYPE       (0)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus.slave),
        .in_port (in_port),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] rd_q [$];
    string       rn_q [$];
    logic        irq_q [$];
    string       in_q [$];

    logic rd_req, rd_vld, irq_req, end_req, end_done;
    int   total, bad;

    initial begin
        total    = 0;
        bad      = 0;
        rd_vld   = 1'b0;
        end_done = 1'b0;
    end

    always @(posedge clk) rd_vld <= rd_req;

    // Monitor: a read presents readdata one edge after issue; irq checks are same-cycle.
    always @(negedge clk) begin
        logic [31:0] e;
        logic        ei;
        string       s;
        if (rd_vld) begin
            total++;
            if (rd_q.size() == 0) begin
                bad++;
                $display("FAIL rd_unexpected: readdata=%h with no expected entry", bus.readdata);
            end else begin
                e = rd_q.pop_front();
                s = rn_q.pop_front();
                if (bus.readdata !== e) begin
                    bad++;
                    $display("FAIL %s: readdata=%h expected=%h", s, bus.readdata, e);
                end
            end
        end
        if (irq_req) begin
            total++;
            if (irq_q.size() == 0) begin
                bad++;
                $display("FAIL irq_unexpected: irq=%b with no expected entry", irq);
            end else begin
                ei = irq_q.pop_front();
                s  = in_q.pop_front();
                if (irq !== ei) begin
                    bad++;
                    $display("FAIL %s: irq=%b expected=%b", s, irq, ei);
                end
            end
        end
        if (end_req && !end_done) begin
            total++;
            if (rd_q.size() != 0 || irq_q.size() != 0) begin
                bad++;
                $display("FAIL drain: rd_left=%0d irq_left=%0d expected=0", rd_q.size(), irq_q.size());
            end
            end_done = 1'b1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [1:0] a, input logic [31:0] exp, input string name);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        rd_req         = 1'b1;
        rd_q.push_back(exp);
        rn_q.push_back(name);
        tick(1);
        rd_req         = 1'b0;
        bus.chipselect = 1'b0;
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        tick(1);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic chk_irq(input logic exp, input string name);
        irq_q.push_back(exp);
        in_q.push_back(name);
        irq_req = 1'b1;
        tick(1);
        irq_req = 1'b0;
    endtask

    initial begin
        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        in_port        = '0;
        reset          = 1'b1;
        rd_req         = 1'b0;
        irq_req        = 1'b0;
        end_req        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // reset state
        do_read(2'd0, 32'h0, "rst_data");
        do_read(2'd1, 32'h0, "rst_rsvd");
        do_read(2'd2, 32'h0, "rst_mask");
        do_read(2'd3, 32'h0, "rst_edge");
        chk_irq(1'b0, "rst_irq");

        // data path, exact input-to-data latency
        in_port = 18'h2A5A5;
        tick(LAT - 1);
        do_read(2'd0, 32'h0, "data_pre");
        do_read(2'd0, 32'h0002A5A5, "data_step");
        do_read(2'd3, 32'h0002A5A5, "edge_step");
        chk_irq(1'b0, "irq_masked_off");
        in_port = '0;
        tick(LAT + 3);
        do_write(2'd3, 32'hFFFFFFFF);
        do_read(2'd3, 32'h0, "edge_clr_all");
        do_read(2'd0, 32'h0, "data_low");

        // 3-cycle pulse on bit 0
        in_port = 18'h1;
        tick(3);
        in_port = '0;
        tick(LAT + 4);
        do_read(2'd0, 32'h0, "reject_data");
        do_read(2'd3, DB_EN ? 32'h0 : 32'h1, "reject_edge");
        do_write(2'd3, 32'hFFFFFFFF);

        // held input is accepted
        in_port = 18'h1;
        tick(LAT - 1);
        do_read(2'd0, 32'h0, "hold_pre");
        do_read(2'd0, 32'h1, "hold_data");
        do_write(2'd3, 32'hFFFFFFFF);
        in_port = '0;
        tick(LAT + 2);
        do_read(2'd3, 32'h0, "hold_clr");

        // edge capture and irq
        do_write(2'd2, 32'h1);
        do_read(2'd2, 32'h1, "mask_rd");
        in_port = 18'h1;
        tick(LAT);
        chk_irq(1'b0, "irq_pre");
        chk_irq(1'b1, "irq_rise");
        do_read(2'd3, 32'h1, "edge_b0");
        in_port = 18'h3;
        tick(LAT + 1);
        do_read(2'd3, 32'h3, "edge_b01");
        chk_irq(1'b1, "irq_hold");
        do_write(2'd3, 32'h1);
        chk_irq(1'b0, "irq_clr");
        do_read(2'd3, 32'h2, "edge_w1c");

        // W1C on the same edge a new rising edge is detected
        in_port = 18'h2;
        tick(LAT + 2);
        in_port = 18'h3;
        tick(LAT);
        do_write(2'd3, 32'h1);
        chk_irq(1'b1, "coll_irq");
        do_read(2'd3, 32'h3, "coll_edge");

        // read-only/reserved writes and mask width
        do_write(2'd0, 32'hFFFFFFFF);
        do_write(2'd1, 32'hFFFFFFFF);
        do_read(2'd0, 32'h3, "wr_ro_data");
        do_read(2'd2, 32'h1, "mask_keep");
        do_write(2'd2, 32'hFFFFFFFF);
        do_read(2'd2, 32'h0003FFFF, "mask_width");
        do_read(2'd1, 32'h0, "rsvd");

        // step on bit 5, then a 1-cycle glitch on bit 6
        in_port = 18'h23;
        tick(LAT - 1);
        do_read(2'd0, 32'h3, "step5_pre");
        do_read(2'd0, 32'h23, "step5");
        in_port = 18'h63;
        tick(1);
        in_port = 18'h23;
        tick(2);
        do_read(2'd0, DB_EN ? 32'h23 : 32'h63, "glitch_data");
        do_read(2'd0, 32'h23, "glitch_gone");

        tick(2);
        end_req = 1'b1;
        for (int i = 0; i < 20 && !end_done; i++) tick(1);
        if (!end_done) begin
            $display("FAIL monitor_timeout: end_done=%b expected=1", end_done);
            $fatal(1, "monitor did not respond");
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
